// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The state encoding is fixed because debug tooling decodes the raw state value.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MULTI    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    localparam int          CNT_W     = 4;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == STALL_MAX) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard inputs from the pipeline and stall/flush controls back to it.
// The master side is the datapath and the slave side is the controller.
interface pipeline_controller_if;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_is_multicycle;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ack;

    logic        pc_wren;
    logic        if_id_wren;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_hold;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_multicycle,
        output ex_is_load, ex_rd, ex_branch_taken, mem_req, mem_ack,
        input  pc_wren, if_id_wren, if_id_flush, id_ex_bubble, ex_hold, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_multicycle,
        input  ex_is_load, ex_rd, ex_branch_taken, mem_req, mem_ack,
        output pc_wren, if_id_wren, if_id_flush, id_ex_bubble, ex_hold, stall_cycles
    );

endinterface

// File: rtl/multicycle_counter.sv
// Loadable down-counter that tracks the remaining EX occupancy of a multi-cycle op.
// It stops at zero so it can never wrap.
module multicycle_counter
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: memory freeze, branch flush, load-use stall
// and multi-cycle EX occupancy, plus a saturating stall-cycle counter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | normal flow; branch flush, load-use and multi-issue decided
//   MULTI    | multi-cycle op occupies EX; front end and EX held
//   MEM_WAIT | memory freeze entered from RUN; waits for mem_ack
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULTI_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pipeline_controller_if.slave  bus
);

    if (MULTI_LATENCY < 2 || MULTI_LATENCY > 16) begin : g_bad_latency
        $error("pipeline_controller: MULTI_LATENCY must be in 2..16");
    end

    localparam logic [CNT_W-1:0] CNT_PRESET = CNT_W'(MULTI_LATENCY - 1);

    ctrl_state_t      state;
    ctrl_state_t      saved_state;
    ctrl_state_t      eff_state;
    logic             freeze;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_hazard;
    logic             run_ok;
    logic             branch_flush;
    logic             load_use_stall;
    logic             multi_issue;
    logic             multi_hold;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             pc_wren;
    logic             if_id_wren;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic [31:0]      stall_cnt;

    assign freeze = bus.mem_req && !bus.mem_ack;

    // On the release cycle of MEM_WAIT the held instructions are re-evaluated
    // as if the controller were back in the state it came from.
    assign eff_state = (state == MEM_WAIT) ? saved_state : state;

    assign rs1_hit     = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
    assign rs2_hit     = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
    assign load_hazard = bus.ex_is_load && (bus.ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    assign run_ok         = reset_n && !freeze && (eff_state == RUN);
    assign branch_flush   = run_ok && bus.ex_branch_taken;
    assign load_use_stall = run_ok && !bus.ex_branch_taken && load_hazard;
    assign multi_issue    = run_ok && !bus.ex_branch_taken && !load_hazard && bus.id_is_multicycle;
    assign multi_hold     = reset_n && !freeze && (state == MULTI);

    multicycle_counter u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (multi_issue),
        .enable     (multi_hold),
        .load_value (CNT_PRESET),
        .count      (cnt),
        .done       (cnt_done)
    );

    always_comb begin
        pc_wren      = 1'b1;
        if_id_wren   = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        if (!reset_n) begin
            pc_wren    = 1'b0;
            if_id_wren = 1'b0;
        end else if (freeze) begin
            pc_wren    = 1'b0;
            if_id_wren = 1'b0;
            ex_hold    = 1'b1;
        end else if (branch_flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use_stall) begin
            pc_wren      = 1'b0;
            if_id_wren   = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (multi_hold) begin
            pc_wren    = 1'b0;
            if_id_wren = 1'b0;
            ex_hold    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            saved_state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state       <= MEM_WAIT;
                        saved_state <= RUN;
                    end else if (multi_issue) begin
                        state <= MULTI;
                    end
                end
                MULTI: begin
                    // A zero count can only mean a corrupted load; leave rather than hang.
                    if (!freeze && (cnt_done || cnt == '0)) begin
                        state <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state <= multi_issue ? MULTI : saved_state;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!pc_wren) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.pc_wren      = pc_wren;
    assign bus.if_id_wren   = if_id_wren;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.ex_hold      = ex_hold;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MULTI_LATENCY, default 4, meaning EX-stage occupancy in cycles of a multi-cycle op; legal range 2..16.
REQ-002 clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction reads rs1 / rs2.
REQ-006 id_is_multicycle  input  1  the ID instruction is a multi-cycle op, e.g. div or FPU.
REQ-007 ex_is_load, ex_rd  input  1, 5  the EX instruction is a load, and its destination register.
REQ-008 ex_branch_taken  input  1  the EX instruction redirects the PC.
REQ-009 mem_req, mem_ack  input  1 each  MEM-stage memory request, and memory completion.
REQ-010 pc_wren, if_id_wren  output  1 each  write enables for the PC register and the IF/ID register.
REQ-011 if_id_flush  output  1  the top level loads 0 into IF/ID.
REQ-012 id_ex_bubble  output  1  ID/EX loads a NOP.
REQ-013 ex_hold  output  1  EX/MEM and ID/EX hold their contents.
REQ-014 stall_cycles  output  32  performance counter.

Function
REQ-015 State register SHALL have three states: RUN, MULTI and MEM_WAIT. Outputs SHALL be combinational from state and inputs (Mealy). State, counters and stall_cycles SHALL be registered.
REQ-016 Default outputs: pc_wren=1, if_id_wren=1, if_id_flush=0, id_ex_bubble=0, ex_hold=0.
REQ-017 Memory freeze SHALL take highest priority. In any state, mem_req=1 with mem_ack=0 gives pc_wren=0, if_id_wren=0, ex_hold=1, if_id_flush=0 and id_ex_bubble=0.
REQ-018 RUN to MEM_WAIT SHALL occur on mem_req=1 with mem_ack=0.
REQ-019 MEM_WAIT SHALL return to its entry state on the cycle mem_ack=1. In that cycle the freeze is released, and the entry state is remembered.
REQ-020 A branch flush (RUN, no freeze, ex_branch_taken=1) SHALL drive if_id_flush=1, id_ex_bubble=1 and pc_wren=1. It overrides load-use and any multi-cycle issue from ID.
REQ-021 Load-use stall condition: RUN, no freeze, no branch, ex_is_load=1, ex_rd!=0, and a matching source (id_uses_rs1 with id_rs1==ex_rd, or id_uses_rs2 with id_rs2==ex_rd).
REQ-022 A load-use stall SHALL drive pc_wren=0, if_id_wren=0 and id_ex_bubble=1. It lasts exactly one cycle, with no state change.
REQ-023 Multi-cycle issue: RUN, no freeze, no branch, no load-use, id_is_multicycle=1. The op SHALL issue normally that cycle, then the controller enters MULTI with cnt=MULTI_LATENCY-1.
REQ-024 In MULTI (no freeze), outputs SHALL be pc_wren=0, if_id_wren=0 and ex_hold=1, and cnt decrements each cycle. At cnt==1 the state returns to RUN next cycle, so the total stall is MULTI_LATENCY-1 cycles.
REQ-025 During a freeze in MULTI, cnt SHALL NOT decrement.
REQ-026 A multi-cycle ID op issued from RUN right after MULTI SHALL re-enter MULTI (back-to-back ops).
REQ-027 cnt width SHALL be 4 bits and SHALL never wrap below 1 while in MULTI.
REQ-028 stall_cycles SHALL increment each cycle with reset_n=1 and pc_wren=0. It saturates at 32'hFFFFFFFF.

Reset
REQ-029 While reset_n=0 at posedge clk: state=RUN, cnt=0, stall_cycles=0, saved entry state=RUN.
REQ-030 During reset cycles, outputs SHALL be pc_wren=0, if_id_wren=0, if_id_flush=0, id_ex_bubble=0 and ex_hold=0.
REQ-031 Reset asserted mid-MULTI or mid-MEM_WAIT SHALL abandon the operation with no residual stall after release.

Structure
REQ-032 Shared package pipeline_ctrl_pkg SHALL hold the state encoding (RUN=2'd0, MULTI=2'd1, MEM_WAIT=2'd2) and the NOP encoding constant.
REQ-033 The loadable down-counter SHALL be sub-module multicycle_counter (load, enable, count, done).
REQ-034 Hazard compare logic SHALL stay inline.

Verification
REQ-035 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_wren=0, if_id_wren=0, id_ex_bubble=1. Next cycle defaults apply; stall_cycles=1.
REQ-036 ex_rd=0 with id_rs1=0 and a load in EX -> no stall.
REQ-037 MULTI_LATENCY=4, id_is_multicycle=1 -> issue cycle, then exactly 3 cycles of ex_hold=1 and pc_wren=0, then RUN.
REQ-038 Freeze mid-MULTI: mem_req=1 for 2 cycles during MULTI -> total stall 5 cycles; stall_cycles=5.
REQ-039 Simultaneous ex_branch_taken=1 and a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_wren=1, no stall.
REQ-040 Reset pulse during MULTI with cnt=2 -> after release, RUN, all defaults, stall_cycles=0.
REQ-041 Counter preset near saturation (force stall_cycles=32'hFFFFFFFE) with 3 stall cycles -> stall_cycles holds at 32'hFFFFFFFF.
